// File: rtl/scanner_byte_sender.sv
// Serialises one parallel byte onto the transfer center's data line: request/ready
// handshake, a high start bit, then the data bits MSB first, each held BIT_CYCLES clocks.
module scanner_byte_sender #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 1,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  ready_for_transfer_in,
  output logic                  data_out,
  output logic                  ready_for_transfer_out,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bit_count
);

  localparam int DIV_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, REQ, START, DATA, DONE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shift_q, shift_next;
  logic [DIV_W-1:0]      div_q, div_next;
  logic [CNT_W-1:0]      bit_next;
  logic                  data_next, rfto_next, busy_next, done_next;
  logic                  div_wrap;

  assign div_wrap = (div_q == DIV_LAST);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    shift_next = shift_q;
    div_next   = div_q;
    bit_next   = bit_count;
    unique case (state)
      IDLE: begin
        if (load) begin
          shift_next = byte_in;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ready_for_transfer_in) begin
          state_next = START;
          div_next   = '0;
        end
      end
      START: begin
        if (div_wrap) begin
          div_next   = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          div_next = div_q + 1'b1;
        end
      end
      DATA: begin
        if (div_wrap) begin
          div_next = '0;
          if (bit_count == BIT_LAST) begin
            bit_next   = '0;
            state_next = DONE;
          end else begin
            bit_next   = bit_count + 1'b1;
            shift_next = {shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          div_next = div_q + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered with it.
    data_next = (state_next == START) || ((state_next == DATA) && shift_next[DATA_WIDTH-1]);
    rfto_next = (state_next == REQ);
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      shift_q                <= '0;
      div_q                  <= '0;
      bit_count              <= '0;
      data_out               <= 1'b0;
      ready_for_transfer_out <= 1'b0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
    end else begin
      state                  <= state_next;
      shift_q                <= shift_next;
      div_q                  <= div_next;
      bit_count              <= bit_next;
      data_out               <= data_next;
      ready_for_transfer_out <= rfto_next;
      busy                   <= busy_next;
      done                   <= done_next;
    end
  end

endmodule

// File: tb/tb_scanner_byte_sender.sv
// Directed bench for scanner_byte_sender: per-cycle expected outputs are queued from a
// frame model when stimulus is driven and compared as the DUT produces them.
module tb_scanner_byte_sender;

  typedef struct packed {
    logic       data_out;
    logic       rfto;
    logic       busy;
    logic       done;
    logic [2:0] bit_count;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       load1, load3;
  logic [7:0] byte1, byte3;
  logic       rdy1, rdy3;
  logic       d1, rfto1, busy1, done1;
  logic       d3, rfto3, busy3, done3;
  logic [2:0] bc1, bc3;

  obs_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  scanner_byte_sender #(.DATA_WIDTH(8), .BIT_CYCLES(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .byte_in(byte1),
    .ready_for_transfer_in(rdy1), .data_out(d1), .ready_for_transfer_out(rfto1),
    .busy(busy1), .done(done1), .bit_count(bc1)
  );

  scanner_byte_sender #(.DATA_WIDTH(8), .BIT_CYCLES(3), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .load(load3), .byte_in(byte3),
    .ready_for_transfer_in(rdy3), .data_out(d3), .ready_for_transfer_out(rfto3),
    .busy(busy3), .done(done3), .bit_count(bc3)
  );

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 3) o = '{data_out: d3, rfto: rfto3, busy: busy3, done: done3, bit_count: bc3};
    else          o = '{data_out: d1, rfto: rfto1, busy: busy1, done: done1, bit_count: bc1};
    return o;
  endfunction

  function automatic obs_t mk(input logic d, input logic r, input logic b,
                              input logic dn, input logic [2:0] c);
    obs_t o;
    o = '{data_out: d, rfto: r, busy: b, done: dn, bit_count: c};
    return o;
  endfunction

  // Sample 1 time unit after the rising edge, then inputs may be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input obs_t obs, input obs_t exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (data,rfto,busy,done,bit_count)", tag, obs, exp);
    end
  endtask

  // Frame model: req_n cycles in REQ, then start bit, data MSB first, DONE, one idle cycle.
  task automatic push_frame(input logic [7:0] b, input int bit_cycles, input int req_n);
    for (int i = 0; i < req_n; i++) q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    for (int j = 0; j < bit_cycles; j++) q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0));
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = i[2:0];
      for (int j = 0; j < bit_cycles; j++) q.push_back(mk(b[7-i], 1'b0, 1'b1, 1'b0, idx));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 3'd0));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
  endtask

  task automatic drain(input int sel, input int n, input string tag);
    obs_t e;
    for (int k = 0; k < n; k++) begin
      tick();
      if (q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL %s: scoreboard empty, observed %b", tag, sample(sel));
      end else begin
        e = q.pop_front();
        chk($sformatf("%s[%0d]", tag, k), sample(sel), e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset hold with load asserted.
    rst = 1'b1; load1 = 1'b1; byte1 = 8'hFF; rdy1 = 1'b1;
    load3 = 1'b1; byte3 = 8'hFF; rdy3 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("reset1[%0d]", k), sample(1), '0);
      chk($sformatf("reset3[%0d]", k), sample(3), '0);
    end
    rst = 1'b0; load1 = 1'b0; load3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_reset1[%0d]", k), sample(1), '0);
      chk($sformatf("post_reset3[%0d]", k), sample(3), '0);
    end

    // Basic frame, one cycle per bit.
    load1 = 1'b1; byte1 = 8'b1011_0010;
    push_frame(8'b1011_0010, 1, 1);
    drain(1, 1, "basic");
    load1 = 1'b0;
    drain(1, q.size(), "basic");

    // Handshake stall: receiver not ready for five cycles.
    rdy1 = 1'b0; load1 = 1'b1; byte1 = 8'h5A;
    push_frame(8'h5A, 1, 5);
    drain(1, 1, "stall");
    load1 = 1'b0;
    drain(1, 4, "stall");
    rdy1 = 1'b1;
    drain(1, q.size(), "stall");

    // Divider, three cycles per bit.
    load3 = 1'b1; byte3 = 8'h81;
    push_frame(8'h81, 3, 1);
    drain(3, 1, "div3");
    load3 = 1'b0;
    drain(3, q.size(), "div3");

    // Loads during DATA and in the DONE cycle are ignored; byte_in changes have no effect.
    load1 = 1'b1; byte1 = 8'hC3;
    push_frame(8'hC3, 1, 1);
    for (int k = 0; k < 3; k++) q.push_back('0);
    drain(1, 1, "ignore");
    load1 = 1'b0;
    drain(1, 4, "ignore");
    load1 = 1'b1; byte1 = 8'h00;
    drain(1, 1, "ignore");
    load1 = 1'b0;
    drain(1, 5, "ignore");
    load1 = 1'b1;
    drain(1, 1, "ignore");
    load1 = 1'b0;
    drain(1, q.size(), "ignore");

    // Reset mid-frame at bit_count 4, then a clean new frame.
    load1 = 1'b1; byte1 = 8'hA5;
    push_frame(8'hA5, 1, 1);
    drain(1, 1, "midrst");
    load1 = 1'b0;
    drain(1, 6, "midrst");
    q.delete();
    rst = 1'b1;
    tick();
    chk("midrst_abort", sample(1), '0);
    rst = 1'b0;
    tick();
    chk("midrst_idle", sample(1), '0);
    load1 = 1'b1; byte1 = 8'h3C;
    push_frame(8'h3C, 1, 1);
    drain(1, 1, "after_rst");
    load1 = 1'b0;
    drain(1, q.size(), "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/scanner_byte_sender.md
Name: scanner_byte_sender

Overview:
- Upstream feeder for the transfer center: takes one parallel byte from a scanner's local buffer and shifts it out serially on the line the transfer center samples as its serial data input.
- Handshakes with the transfer center's ready-for-transfer signal before sending.
- Frames each byte with a start bit so the receiver can detect the start of the byte and count bits into its byte counter.

Parameters:
- DATA_WIDTH, 8: bits per transferred word.
- BIT_CYCLES, 1: clock cycles each serial bit is held on data_out; must be ≥1.
- CNT_W, 3: width of the bit counter; must satisfy 2^CNT_W ≥ DATA_WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  request to send byte_in; sampled only in IDLE.
- byte_in  input  DATA_WIDTH  byte to send; captured on the accepting edge.
- ready_for_transfer_in  input  1  receiver (transfer center) ready to accept a byte.
- data_out  output  1  serial line to the transfer center's data input.
- ready_for_transfer_out  output  1  request-to-send flag; high while waiting for the receiver.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last data bit.
- bit_count  output  CNT_W  index of the data bit currently on the line; 0 outside DATA.

Behaviour:
- Reset: a synchronous rst (rising edge with rst=1) forces the following:
  - state=IDLE
  - data_out=0, ready_for_transfer_out=0, busy=0, done=0, bit_count=0
  - shift register and divider cleared
  - rst mid-frame aborts the frame immediately; the line returns to 0 on that edge.
- All outputs are registered. Line idle level is 0.
- States: IDLE, REQ, START, DATA, DONE.
- IDLE:
  - load=1 captures byte_in into the shift register and moves to REQ.
  - load=0: stay in IDLE.
- REQ:
  - ready_for_transfer_out=1, data_out=0.
  - If ready_for_transfer_in=1 is sampled, go to START; otherwise stay indefinitely. There is no timeout.
  - Entering START drops ready_for_transfer_out on the same edge.
- START: data_out=1 for BIT_CYCLES cycles, then go to DATA with bit_count=0.
- DATA:
  - data_out = shift register MSB; bits are sent MSB first.
  - Each bit is held for BIT_CYCLES cycles, then the register shifts left and bit_count increments.
  - After bit DATA_WIDTH-1 completes its BIT_CYCLES, go to DONE.
- DONE: done=1 and data_out=0 for exactly one cycle, then return to IDLE.
- Latency: with the accepting edge at cycle 0 and ready_for_transfer_in already high:
  - START occupies cycles 2..(1+BIT_CYCLES).
  - done is high at cycle 2+(1+DATA_WIDTH)*BIT_CYCLES.
  - busy is high from cycle 1 through the done cycle inclusive.
- load while busy is ignored; byte_in changes after capture have no effect.
- ready_for_transfer_in deasserting after REQ is left has no effect; the frame always completes.
- load=1 in the DONE cycle is ignored. load is accepted no earlier than the first IDLE cycle, so there is one mandatory idle-low cycle between frames.
- Divider counts 0..BIT_CYCLES-1 and wraps. With BIT_CYCLES=1 every state bit lasts exactly one cycle.
- bit_count does not wrap during a frame; its maximum value is DATA_WIDTH-1.

Test Plan:
- Reset hold: rst=1 for 2 cycles with load=1 and byte_in=8'hFF → all outputs 0, state stays IDLE, no REQ after rst falls until load is sampled again.
- Basic frame, BIT_CYCLES=1: ready_for_transfer_in=1, load byte_in=8'b10110010 → ready_for_transfer_out=1 for 1 cycle, then data_out sequence 1,1,0,1,1,0,0,1,0 (start bit + data). bit_count steps 0..7, done pulses 1 cycle, busy low the following cycle.
- Handshake stall: ready_for_transfer_in=0 for 5 cycles after load → ready_for_transfer_out and busy stay 1 and data_out stays 0. Raising ready_for_transfer_in → start bit on the next cycle.
- Divider, BIT_CYCLES=3: byte 8'h81 → start bit high 3 cycles, then 1 for 3 cycles, 0 for 18 cycles, 1 for 3 cycles; done at cycle 2+27=29 after accept.
- Ignored loads: pulse load with byte_in=8'h00 during DATA and in the DONE cycle → original byte transmitted unchanged, no second frame starts.
- Reset mid-frame: assert rst at bit_count=4 → data_out, busy and bit_count=0 after that edge. A new load afterwards sends the full new byte from its start bit.
